// File: rtl/morse_char_sched.sv
// Morse character scheduler: ASCII FIFO with a valid/ready output register.
// Define MORSE_WORD_SPACE_EN to insert a space (8'h20) after a word-length key-up gap.
module morse_char_sched #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WORD_SPACE = 200000000,
  parameter int unsigned TIMER_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   morse_in,
  input  logic [7:0]             char_in,
  input  logic                   char_in_valid,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [7:0]  SPACE_CHAR = 8'h20;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic       rd_en, can_write, wr_req, wr_acc;
  logic       space_req, space_clash;
  logic [7:0] wr_data;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign rd_en     = (count_q != '0) && (!out_valid_q || out_ready);
  assign can_write = (count_q < CNT_W'(DEPTH)) || rd_en;
  assign wr_req    = char_in_valid || space_req;
  assign wr_acc    = wr_req && can_write;
  assign wr_data   = char_in_valid ? char_in : SPACE_CHAR;

`ifdef MORSE_WORD_SPACE_EN
  typedef enum logic [1:0] {
    GAP_IDLE,
    GAP_ARMED,
    GAP_PENDING
  } gap_state_e;

  gap_state_e         gap_q, gap_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               at_gap;

  assign at_gap = (timer_q == TIMER_W'(WORD_SPACE));

  // Gap FSM: timer only runs while ARMED, so it never passes WORD_SPACE.
  always_comb begin
    gap_d       = gap_q;
    timer_d     = '0;
    space_req   = 1'b0;
    space_clash = 1'b0;
    unique case (gap_q)
      GAP_IDLE: begin
        if (char_in_valid && can_write) gap_d = GAP_ARMED;
      end
      GAP_ARMED: begin
        if (at_gap) begin
          if (char_in_valid) begin
            gap_d = GAP_PENDING;
          end else begin
            space_req = 1'b1;
            gap_d     = GAP_IDLE;
          end
        end else if (!morse_in) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      GAP_PENDING: begin
        if (char_in_valid) begin
          space_clash = 1'b1;
          gap_d       = GAP_ARMED;
        end else begin
          space_req = 1'b1;
          gap_d     = GAP_IDLE;
        end
      end
      default: gap_d = GAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q   <= GAP_IDLE;
      timer_q <= '0;
    end else begin
      gap_q   <= gap_d;
      timer_q <= timer_d;
    end
  end
`else
  logic unused_cfg;

  assign space_req   = 1'b0;
  assign space_clash = 1'b0;
  assign unused_cfg  = morse_in ^ (WORD_SPACE == 0) ^ (TIMER_W == 0);
`endif

  // FIFO pointers, occupancy, output register and sticky overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_char_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({wr_acc, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clear_ovf) ovf_d = 1'b0;
    if ((wr_req && !wr_acc) || space_clash) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_char   = out_char_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_morse_char_sched.sv
// Scoreboard bench for morse_char_sched; gap-space cases run when MORSE_WORD_SPACE_EN is defined.
module tb_morse_char_sched;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WS    = 20;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk           = 1'b0;
  logic             reset         = 1'b1;
  logic             morse_in      = 1'b1;
  logic [7:0]       char_in       = 8'h00;
  logic             char_in_valid = 1'b0;
  logic             out_ready     = 1'b0;
  logic             clear_ovf     = 1'b0;
  logic [7:0]       out_char;
  logic             out_valid;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  morse_char_sched #(
    .DEPTH     (DEPTH),
    .WORD_SPACE(WS),
    .TIMER_W   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .morse_in     (morse_in),
    .char_in      (char_in),
    .char_in_valid(char_in_valid),
    .out_char     (out_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every accepted output is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check_eq("out_char", 32'(out_char), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    char_in_valid = 1'b0;
    clear_ovf     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    char_in       = c;
    char_in_valid = 1'b1;
    exp_q.push_back(c);
    tick();
    char_in_valid = 1'b0;
  endtask

  task automatic send_drop(input logic [7:0] c);
    char_in       = c;
    char_in_valid = 1'b1;
    tick();
    char_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    out_ready = 1'b1;
    do_reset();
    sample();
    check_eq("rst_out_char", 32'(out_char), 32'h00);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // S-O-S with sink always ready; first out_valid two edges after the strobe.
    tick();
    send(8'h53);
    sample();
    check_eq("lat_edge_n", 32'(out_valid), 32'd0);
    tick();
    sample();
    check_eq("lat_edge_n1", 32'(out_valid), 32'd1);
    check_eq("lat_char", 32'(out_char), 32'h53);
    tick();
    send(8'h4F);
    tick();
    send(8'h53);
    drain("sos_drain");
    ticks(3);
    sample();
    check_eq("sos_idle", 32'(out_valid), 32'd0);

    // Fill with sink stalled: 16 stored plus one in the output register.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
    sample();
    check_eq("fill16_count", 32'(fifo_count), 32'd15);
    check_eq("fill16_valid", 32'(out_valid), 32'd1);
    check_eq("fill16_ovf", 32'(overflow), 32'd0);
    tick();
    send(8'h71);
    sample();
    check_eq("fill17_count", 32'(fifo_count), 32'd16);
    check_eq("fill17_ovf", 32'(overflow), 32'd0);
    tick();
    send_drop(8'h72);
    sample();
    check_eq("drop_ovf", 32'(overflow), 32'd1);
    check_eq("drop_count", 32'(fifo_count), 32'd16);
    check_eq("stall_char", 32'(out_char), 32'h61);
    tick();
    clear_ovf = 1'b1;
    send_drop(8'h73);
    clear_ovf = 1'b0;
    sample();
    check_eq("ovf_set_wins", 32'(overflow), 32'd1);
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    sample();
    check_eq("ovf_clear", 32'(overflow), 32'd0);
    tick();
    out_ready = 1'b1;
    send(8'h5A);
    sample();
    check_eq("full_rw_count", 32'(fifo_count), 32'd16);
    check_eq("full_rw_ovf", 32'(overflow), 32'd0);
    drain("fill_drain");
    ticks(2);
    sample();
    check_eq("fill_idle", 32'(out_valid), 32'd0);

`ifdef MORSE_WORD_SPACE_EN
    // No space before any character, then exactly one space after the gap.
    do_reset();
    morse_in = 1'b0;
    ticks(50);
    sample();
    check_eq("boot_no_space", 32'(out_valid), 32'd0);
    check_eq("boot_count", 32'(fifo_count), 32'd0);
    tick();
    send(8'h45);
    ticks(20);
    sample();
    check_eq("gap_pre", 32'(fifo_count), 32'd0);
    tick();
    sample();
    check_eq("gap_at", 32'(fifo_count), 32'd1);
    exp_q.push_back(8'h20);
    tick();
    sample();
    check_eq("gap_valid", 32'(out_valid), 32'd1);
    ticks(100);
    sample();
    check_eq("no_second_space", 32'(fifo_count), 32'd0);
    check_eq("gap_idle", 32'(out_valid), 32'd0);
    drain("gap_drain");

    // Key press at timer=10 restarts the gap count.
    do_reset();
    send(8'h54);
    ticks(10);
    morse_in = 1'b1;
    tick();
    morse_in = 1'b0;
    ticks(20);
    sample();
    check_eq("restart_pre", 32'(fifo_count), 32'd0);
    tick();
    sample();
    check_eq("restart_at", 32'(fifo_count), 32'd1);
    exp_q.push_back(8'h20);
    drain("restart_drain");

    // Char on the trigger cycle: char first, space next.
    do_reset();
    send(8'h45);
    ticks(20);
    send(8'h41);
    exp_q.push_back(8'h20);
    drain("pend_drain");
    sample();
    check_eq("pend_ovf", 32'(overflow), 32'd0);

    // Chars on trigger and pending cycles: space dropped, timer re-armed from 0.
    do_reset();
    send(8'h45);
    ticks(20);
    send(8'h41);
    send(8'h42);
    sample();
    check_eq("clash_ovf", 32'(overflow), 32'd1);
    exp_q.push_back(8'h20);
    ticks(20);
    sample();
    check_eq("rearm_pre", 32'(fifo_count), 32'd0);
    tick();
    sample();
    check_eq("rearm_at", 32'(fifo_count), 32'd1);
    drain("clash_drain");
    morse_in = 1'b1;
`else
    // Without the gap feature a long key-up never yields a space.
    do_reset();
    send(8'h45);
    morse_in = 1'b0;
    ticks(10 * WS);
    sample();
    check_eq("off_count", 32'(fifo_count), 32'd0);
    check_eq("off_valid", 32'(out_valid), 32'd0);
    drain("off_drain");
    morse_in = 1'b1;
`endif

    ticks(2);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
